ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Two-requester arbiter and sequencer for the 16-bit word RAM (r/w/addr/D/o).
//  Grants one requester at a time and drives the RAM read/write strobes.
//  Captures read data into a per-requester register and returns a one-cycle ack.
//  Sits between the two client ports (A, B) and a single RAM instance.
// PARAMETERS
//  DATA_W  16  RAM word width
//  ADDR_W  8   RAM address width
//  RD_LAT  1   cycles ram_r is held before ram_q is sampled; must be >= 1
// PORTS
//  clk       in   1       system clock, rising edge
//  rst_n     in   1       asynchronous active-low reset
//  a_req     in   1       port A request; level, held until a_ack
//  a_we      in   1       port A: 1 = write, 0 = read
//  a_addr    in   ADDR_W  port A address
//  a_wdata   in   DATA_W  port A write data
//  a_ack     out  1       port A done, one-cycle pulse
//  a_rdata   out  DATA_W  port A last read data
//  b_*       -    -       same set as a_* for port B
//  ram_r     out  1       RAM read enable
//  ram_w     out  1       RAM write enable
//  ram_addr  out  ADDR_W  RAM address
//  ram_d     out  DATA_W  RAM write data
//  ram_q     in   DATA_W  RAM read data
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; ram_r, ram_w, a_ack, b_ack = 0.
//    ram_addr, ram_d, a_rdata, b_rdata = 0. last_grant = B, so A wins first tie.
//  - FSM has three states: IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE: sample a_req/b_req. If either is set, latch winner's we/addr/wdata
//    and grant id, then go to ACCESS. If neither is set, stay in IDLE.
//  - Round robin: one request -> that port wins. Both -> port != last_grant
//    wins. last_grant updates at grant.
//  - ACCESS write: ram_w=1 with latched addr/data for exactly 1 cycle.
//  - ACCESS read: ram_r=1 with latched addr for RD_LAT cycles (counter).
//    ram_q is captured into the granted port's rdata on the last ACCESS edge.
//  - DONE: granted port's ack=1 for one cycle; ram_r = ram_w = 0; go to IDLE.
//  - Latency from req sampled in IDLE to ack: write = 2 cycles;
//    read = RD_LAT + 1 cycles. Min issue interval = 3 cycles (write).
//  - Outside ACCESS: ram_r = ram_w = 0. ram_addr/ram_d hold their last values.
//  - rdata of a port changes only on that port's read completion.
//    Writes never change rdata.
//  - req held high past ack = new request, re-arbitrated in the next IDLE.
//  - req dropped before grant: ignored.
//  - req dropped mid-ACCESS: transaction still completes and ack still pulses.
//  - Reset asserted mid-transaction: strobes drop asynchronously, no ack,
//    rdata cleared. The RAM word may be partially written; clients must retry.
//  - ram_r and ram_w are never high together. At most one ack per cycle.
// CONFIGURATION
//  RAM_ARB_FIXED_PRIO_EN defined: fixed priority, A always beats B;
//    last_grant is unused. B can starve if A requests continuously.
//  Undefined (default): round robin as above.
// TESTING
//  1. Hold rst_n=0 -> all outputs 0. Release, idle 5 cycles -> ram_r = ram_w = 0, no ack.
//  2. A writes 128 to addr 15 -> next cycle ram_w=1, ram_addr=15, ram_d=128 for
//     1 cycle; a_ack pulses 2 cycles after req sampled.
//  3. A then reads addr 15 (RD_LAT=1) -> ram_r=1 one cycle;
//     a_rdata=128 with a_ack; b_rdata stays 0.
//  4. A and B both request continuously (A write 11<-64, B read 11) ->
//     grants A,B,A,B. B reads 64. Under RAM_ARB_FIXED_PRIO_EN: A,A,A and B never acks.
//  5. RD_LAT=3, B reads addr 7 -> ram_r high 3 cycles; b_ack 4 cycles after
//     sample; data = value at the 3rd edge.
//  6. Assert rst_n=0 during a read's ACCESS -> ram_r drops immediately, no ack.
//     After release, the FSM is in IDLE and the A-first tie-break holds.

Source files
------------

// File: rtl/ram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ram_port_arbiter : two-client arbiter and sequencer for one 16-bit word RAM.
// Optional macro RAM_ARB_FIXED_PRIO_EN selects fixed A-over-B priority.
// Revision: 1.0
// ============================================================================
module ram_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_r,
  output logic              ram_w,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int              CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ram_r_q, ram_r_d;
  logic              ram_w_q, ram_w_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_d_q, ram_d_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic              w_any_req;
  logic              w_win_b;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_last_access;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign w_win_b = ~a_req;
`else
  logic last_grant_q, last_grant_d;

  // On a tie the port that did not win last time gets the grant.
  assign w_win_b = b_req & (~a_req | (last_grant_q == PORT_A));
`endif

  assign w_any_req     = a_req | b_req;
  assign w_win_we      = w_win_b ? b_we    : a_we;
  assign w_win_addr    = w_win_b ? b_addr  : a_addr;
  assign w_win_wdata   = w_win_b ? b_wdata : a_wdata;
  assign w_last_access = we_q | (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    ram_r_d    = ram_r_q;
    ram_w_d    = ram_w_q;
    ram_addr_d = ram_addr_q;
    ram_d_d    = ram_d_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (w_any_req) begin
          gnt_d      = w_win_b;
          we_d       = w_win_we;
          cnt_d      = '0;
          ram_addr_d = w_win_addr;
          // ram_d only follows writes so it keeps the last written word.
          if (w_win_we) begin
            ram_d_d = w_win_wdata;
            ram_w_d = 1'b1;
          end else begin
            ram_r_d = 1'b1;
          end
`ifndef RAM_ARB_FIXED_PRIO_EN
          last_grant_d = w_win_b;
`endif
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (w_last_access) begin
          ram_r_d = 1'b0;
          ram_w_d = 1'b0;
          state_d = S_DONE;
          if (gnt_q == PORT_B) begin
            b_ack_d = 1'b1;
            if (!we_q) b_rdata_d = ram_q;
          end else begin
            a_ack_d = 1'b1;
            if (!we_q) a_rdata_d = ram_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        ram_r_d = 1'b0;
        ram_w_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= PORT_A;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      ram_r_q    <= 1'b0;
      ram_w_q    <= 1'b0;
      ram_addr_q <= '0;
      ram_d_q    <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      ram_r_q    <= ram_r_d;
      ram_w_q    <= ram_w_d;
      ram_addr_q <= ram_addr_d;
      ram_d_q    <= ram_d_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

`ifndef RAM_ARB_FIXED_PRIO_EN
  // Reset to B so that A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= PORT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign ram_r    = ram_r_q;
  assign ram_w    = ram_w_q;
  assign ram_addr = ram_addr_q;
  assign ram_d    = ram_d_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule
`default_nettype wire
